// File: rtl/pll_lock_seq.sv
// pll_lock_seq: reset/lock sequencer for the DDR3 core PLL wrapper.
// Holds the PLL in reset and then waits for a synchronized, stable lock.
// It then enables CLKOUT0 and finally releases the downstream DDR reset.
// A lock timeout or a loss of lock re-sequences the PLL automatically.
// Optional feature macro: PLL_LOCK_SEQ_LOSS_CNT_EN adds lock_loss_cnt and
// lock_lost_sticky, which track GATE/RUN lock losses.
module pll_lock_seq #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int STABLE_CYCLES = 1024,
  parameter int GATE_DLY      = 8,
  parameter int CNT_W         = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic       clkout0_gate,
  output logic       ddr_rst,
  output logic       seq_done,
  output logic [3:0] retry_cnt,
  output logic [2:0] state_o
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
  ,
  output logic [7:0] lock_loss_cnt,
  output logic       lock_lost_sticky
`endif
);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    GATE      = 3'd3,
    RUN       = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GATE_LAST    = CNT_W'(GATE_DLY - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retryCnt_q, retryCnt_d;
  logic             lockSync_q, lockS_q;
  logic             pllRst_q, pllRst_d;
  logic             gate_q, gate_d;
  logic             ddrRst_q, ddrRst_d;
  logic             seqDone_q, seqDone_d;
  logic             lossEvent;

  // Two-flop synchronizer for the asynchronous PLL lock; rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      lockSync_q <= 1'b0;
      lockS_q    <= 1'b0;
    end else begin
      lockSync_q <= pll_lock;
      lockS_q    <= lockSync_q;
    end
  end

  // Next-state logic for the sequencer. The outputs are derived from the
  // next state, so every output register changes together with the state.
  // The STABLE compare uses >=. With STABLE_CYCLES=1 the entry value of 1
  // is already past the limit, so the count still completes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    retryCnt_d = retryCnt_q;
    lossEvent  = 1'b0;
    case (state_q)
      PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WAIT_LOCK: begin
        if (lockS_q) begin
          state_d = STABLE;
          cnt_d   = CNT_ONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = PLL_RST;
          cnt_d   = '0;
          if (retryCnt_q != 4'hF) begin
            retryCnt_d = retryCnt_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE: begin
        if (!lockS_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q >= STABLE_LAST) begin
          state_d = GATE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      GATE: begin
        if (!lockS_q) begin
          state_d   = PLL_RST;
          cnt_d     = '0;
          lossEvent = 1'b1;
        end else if (cnt_q == GATE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!lockS_q) begin
          state_d   = PLL_RST;
          lossEvent = 1'b1;
        end
      end
      default: begin
        state_d = PLL_RST;
        cnt_d   = '0;
      end
    endcase

    pllRst_d  = (state_d == PLL_RST);
    gate_d    = (state_d == GATE) || (state_d == RUN);
    ddrRst_d  = (state_d != RUN);
    seqDone_d = (state_d == RUN);
  end

  // State, counter, retry count and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PLL_RST;
      cnt_q      <= '0;
      retryCnt_q <= 4'd0;
      pllRst_q   <= 1'b1;
      gate_q     <= 1'b0;
      ddrRst_q   <= 1'b1;
      seqDone_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retryCnt_q <= retryCnt_d;
      pllRst_q   <= pllRst_d;
      gate_q     <= gate_d;
      ddrRst_q   <= ddrRst_d;
      seqDone_q  <= seqDone_d;
    end
  end

  assign pll_rst      = pllRst_q;
  assign clkout0_gate = gate_q;
  assign ddr_rst      = ddrRst_q;
  assign seq_done     = seqDone_q;
  assign retry_cnt    = retryCnt_q;
  assign state_o      = state_q;

`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
  logic [7:0] lossCnt_q;
  logic       lossSticky_q;

  // Count GATE/RUN lock losses, saturating, and remember that one happened.
  always_ff @(posedge clk) begin
    if (rst) begin
      lossCnt_q    <= 8'd0;
      lossSticky_q <= 1'b0;
    end else if (lossEvent) begin
      if (lossCnt_q != 8'hFF) begin
        lossCnt_q <= lossCnt_q + 8'd1;
      end
      lossSticky_q <= 1'b1;
    end
  end

  assign lock_loss_cnt    = lossCnt_q;
  assign lock_lost_sticky = lossSticky_q;
`else
  logic unusedLoss;
  assign unusedLoss = lossEvent;
`endif

endmodule
